// File: rtl/hsiao_ecc_scrub_memory.sv
// Hsiao SEC-DED protected register memory with fault injection and a
// background scrubber that rewrites words whose single-bit errors it corrects.
// Ports: clk/rst (async, active low); host write (wr_*); host read (rd_*),
// which returns corrected data one cycle later with sec/ded flags; fault
// injection (inj_*); scrub_en/scrub_busy for the scrubber; and saturating
// sec_count/ded_count event counters.
module hsiao_ecc_scrub_memory #(
  parameter  int DATA_W         = 8,
  parameter  int ADDR_W         = 4,
  parameter  int SCRUB_INTERVAL = 64,
  localparam int CHECK_W = (DATA_W <= 8) ? 5 : (DATA_W <= 16) ? 6 : 7,
  localparam int CW      = DATA_W + CHECK_W,
  localparam int BW      = $clog2(CW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_sec,
  output logic              rd_ded,
  input  logic              inj_en,
  input  logic              inj_two_bit,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [BW-1:0]     inj_bit1,
  input  logic [BW-1:0]     inj_bit2,
  input  logic              scrub_en,
  output logic [15:0]       sec_count,
  output logic [15:0]       ded_count,
  output logic              scrub_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [15:0] IVL_LAST = 16'(SCRUB_INTERVAL - 1);

  typedef logic [CHECK_W-1:0] syn_t;
  typedef logic [CW-1:0] cw_t;
  typedef logic [DATA_W-1:0][CHECK_W-1:0] hmat_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sec;
    logic              ded;
  } dec_t;

  // Data columns: the first DATA_W weight-3 patterns in numeric order.
  // Check bits own the weight-1 columns.
  function automatic hmat_t gen_h();
    hmat_t h;
    int n;
    h = '0;
    n = 0;
    for (int v = 0; v < (1 << CHECK_W); v++) begin
      if ($countones(v) == 3 && n < DATA_W) begin
        h[n] = syn_t'(v);
        n++;
      end
    end
    return h;
  endfunction

  localparam hmat_t H = gen_h();

  function automatic syn_t parity(input logic [DATA_W-1:0] d);
    syn_t p;
    p = '0;
    for (int i = 0; i < DATA_W; i++)
      if (d[i]) p = p ^ H[i];
    return p;
  endfunction

  function automatic cw_t encode(input logic [DATA_W-1:0] d);
    return {parity(d), d};
  endfunction

  function automatic dec_t decode(input cw_t w);
    dec_t r;
    syn_t s;
    logic zero;
    logic odd;
    logic hit;
    s      = w[CW-1:DATA_W] ^ parity(w[DATA_W-1:0]);
    zero   = (s == '0);
    odd    = ^s;
    r.data = w[DATA_W-1:0];
    r.sec  = 1'b0;
    r.ded  = 1'b0;
    hit    = ($countones(s) == 1);
    unique case (1'b1)
      zero: ;
      (!zero && !odd): r.ded = 1'b1;
      odd: begin
        for (int i = 0; i < DATA_W; i++) begin
          if (s == H[i]) begin
            r.data[i] = ~r.data[i];
            hit = 1'b1;
          end
        end
        r.sec = hit;
        r.ded = !hit;
      end
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_add(
    input logic [15:0] c,
    input logic        a,
    input logic        b
  );
    logic [16:0] s;
    s = 17'(c) + 17'(a) + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READ, S_CHECK, S_WB
  } state_t;

  cw_t               mem [DEPTH];
  cw_t               inj_mask;
  dec_t              host_dec;
  dec_t              scr_dec;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic [15:0]       ivl, ivl_nx;
  cw_t               scr_word, scr_nx;
  logic              wb_fire;
  logic              scr_sec;
  logic              scr_ded;
  logic              hit_ptr;

  // Out-of-range indices flip nothing; equal indices cancel.
  always_comb begin
    inj_mask = '0;
    if (32'(inj_bit1) < CW)
      inj_mask[inj_bit1] = 1'b1;
    if (inj_two_bit && 32'(inj_bit2) < CW)
      inj_mask[inj_bit2] = ~inj_mask[inj_bit2];
  end

  always_comb begin
    host_dec = decode(mem[rd_addr]);
    scr_dec  = decode(scr_word);
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    ivl_nx   = ivl;
    scr_nx   = scr_word;
    wb_fire  = 1'b0;
    scr_sec  = 1'b0;
    scr_ded  = 1'b0;
    hit_ptr  = (wr_en && wr_addr == ptr)
            || (inj_en && inj_addr == ptr);
    if (!scrub_en) begin
      state_nx = S_IDLE;
      ivl_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_WAIT;
          ivl_nx   = '0;
        end
        S_WAIT: begin
          if (ivl == IVL_LAST) begin
            ivl_nx   = '0;
            state_nx = S_READ;
          end else begin
            ivl_nx = ivl + 16'd1;
          end
        end
        S_READ: begin
          if (!(wr_en || inj_en)) begin
            scr_nx   = mem[ptr];
            state_nx = S_CHECK;
          end
        end
        S_CHECK: begin
          scr_sec = scr_dec.sec;
          scr_ded = scr_dec.ded;
          scr_nx  = encode(scr_dec.data);
          // A host access to the word since READ makes the copy stale.
          if (scr_dec.sec && !hit_ptr) begin
            state_nx = S_WB;
          end else begin
            state_nx = S_WAIT;
            ptr_nx   = ptr + ADDR_W'(1);
          end
        end
        S_WB: begin
          if (hit_ptr) begin
            state_nx = S_WAIT;
            ptr_nx   = ptr + ADDR_W'(1);
          end else if (!wr_en) begin
            wb_fire  = 1'b1;
            state_nx = S_WAIT;
            ptr_nx   = ptr + ADDR_W'(1);
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      ivl      <= '0;
      scr_word <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      ivl      <= ivl_nx;
      scr_word <= scr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (wr_en && wr_addr == ADDR_W'(a))
          mem[a] <= encode(wr_data);
        else if (inj_en && inj_addr == ADDR_W'(a))
          mem[a] <= mem[a] ^ inj_mask;
        else if (wb_fire && ptr == ADDR_W'(a))
          mem[a] <= scr_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_sec    <= 1'b0;
      rd_ded    <= 1'b0;
      sec_count <= '0;
      ded_count <= '0;
    end else begin
      rd_valid  <= rd_en;
      rd_sec    <= rd_en & host_dec.sec;
      rd_ded    <= rd_en & host_dec.ded;
      if (rd_en) rd_data <= host_dec.data;
      sec_count <= sat_add(sec_count, rd_en & host_dec.sec, scr_sec);
      ded_count <= sat_add(ded_count, rd_en & host_dec.ded, scr_ded);
    end
  end

  assign scrub_busy = (state != S_IDLE);

endmodule

// File: tb/tb_hsiao_ecc_scrub_memory.sv
// Directed bench for hsiao_ecc_scrub_memory (DATA_W=8, ADDR_W=4,
// SCRUB_INTERVAL=4): read/write, injection, scrub repair, reset, saturation.
module tb_hsiao_ecc_scrub_memory;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_sec;
  logic       rd_ded;
  logic       inj_en;
  logic       inj_two_bit;
  logic [3:0] inj_addr;
  logic [3:0] inj_bit1;
  logic [3:0] inj_bit2;
  logic       scrub_en;
  logic [15:0] sec_count;
  logic [15:0] ded_count;
  logic       scrub_busy;

  int n_chk;
  int n_pass;

  hsiao_ecc_scrub_memory #(
    .DATA_W(8),
    .ADDR_W(4),
    .SCRUB_INTERVAL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_sec(rd_sec),
    .rd_ded(rd_ded),
    .inj_en(inj_en),
    .inj_two_bit(inj_two_bit),
    .inj_addr(inj_addr),
    .inj_bit1(inj_bit1),
    .inj_bit2(inj_bit2),
    .scrub_en(scrub_en),
    .sec_count(sec_count),
    .ded_count(ded_count),
    .scrub_busy(scrub_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic inj(
    input logic [3:0] a,
    input logic [3:0] b1,
    input logic [3:0] b2,
    input logic       two
  );
    inj_en = 1'b1;
    inj_addr = a;
    inj_bit1 = b1;
    inj_bit2 = b2;
    inj_two_bit = two;
    step();
    inj_en = 1'b0;
  endtask

  task automatic rd(
    input string      tag,
    input logic [3:0] a,
    input logic [7:0] d,
    input logic       sec,
    input logic       ded
  );
    rd_en = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(d));
    chk({tag, "_sec"}, 32'(rd_sec), 32'(sec));
    chk({tag, "_ded"}, 32'(rd_ded), 32'(ded));
  endtask

  task automatic wait_scrub_sec(input string tag);
    logic [15:0] prev;
    logic        seen;
    prev = sec_count;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (sec_count != prev) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en = 1'b0;
    rd_addr = '0;
    inj_en = 1'b0;
    inj_two_bit = 1'b0;
    inj_addr = '0;
    inj_bit1 = '0;
    inj_bit2 = '0;
    scrub_en = 1'b0;
    repeat (2) step();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_sec", 32'(rd_sec), 32'd0);
    chk("rst_ded", 32'(rd_ded), 32'd0);
    chk("rst_seccnt", 32'(sec_count), 32'd0);
    chk("rst_dedcnt", 32'(ded_count), 32'd0);
    chk("rst_busy", 32'(scrub_busy), 32'd0);
    rst = 1'b1;
    step();

    wr(4'd3, 8'hA5);
    rd("rd3", 4'd3, 8'hA5, 1'b0, 1'b0);
    step();
    chk("valid_pulse", 32'(rd_valid), 32'd0);

    inj(4'd3, 4'd2, 4'd2, 1'b0);
    rd("sec3", 4'd3, 8'hA5, 1'b1, 1'b0);
    chk("seccnt1", 32'(sec_count), 32'd1);
    rd("sec3_again", 4'd3, 8'hA5, 1'b1, 1'b0);
    chk("seccnt2", 32'(sec_count), 32'd2);

    wr(4'd5, 8'h3C);
    inj(4'd5, 4'd0, 4'd7, 1'b1);
    rd("ded5", 4'd5, 8'hBD, 1'b0, 1'b1);
    chk("dedcnt1", 32'(ded_count), 32'd1);
    wr(4'd5, 8'h3C);

    wr(4'd6, 8'h5A);
    inj(4'd6, 4'd4, 4'd4, 1'b1);
    rd("same_bits", 4'd6, 8'h5A, 1'b0, 1'b0);
    inj(4'd6, 4'd13, 4'd0, 1'b0);
    rd("oob_bit", 4'd6, 8'h5A, 1'b0, 1'b0);
    inj(4'd6, 4'd12, 4'd0, 1'b0);
    rd("chkbit", 4'd6, 8'h5A, 1'b1, 1'b0);
    chk("seccnt3", 32'(sec_count), 32'd3);
    wr(4'd6, 8'h5A);

    inj(4'd8, 4'd1, 4'd14, 1'b1);
    rd("two_oob", 4'd8, 8'h00, 1'b1, 1'b0);
    chk("seccnt4", 32'(sec_count), 32'd4);
    wr(4'd8, 8'h00);

    wr(4'd15, 8'hFF);
    rd("top_addr", 4'd15, 8'hFF, 1'b0, 1'b0);

    wr(4'd7, 8'h11);
    wr_en = 1'b1;
    wr_addr = 4'd7;
    wr_data = 8'h22;
    rd_en = 1'b1;
    rd_addr = 4'd7;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("rbw_old", 32'(rd_data), 32'h11);
    rd("rbw_new", 4'd7, 8'h22, 1'b0, 1'b0);

    scrub_en = 1'b1;
    step();
    chk("scrub_busy", 32'(scrub_busy), 32'd1);
    repeat (150) step();
    chk("scrub_seccnt", 32'(sec_count), 32'd5);
    chk("scrub_dedcnt", 32'(ded_count), 32'd1);
    scrub_en = 1'b0;
    step();
    chk("scrub_idle", 32'(scrub_busy), 32'd0);
    rd("scrubbed3", 4'd3, 8'hA5, 1'b0, 1'b0);
    chk("seccnt_after", 32'(sec_count), 32'd5);

    wr(4'd10, 8'h42);
    inj(4'd10, 4'd3, 4'd3, 1'b0);
    scrub_en = 1'b1;
    wait_scrub_sec("wb_wait");
    wr(4'd10, 8'h77);
    scrub_en = 1'b0;
    step();
    rd("wb_skip", 4'd10, 8'h77, 1'b0, 1'b0);
    chk("seccnt6", 32'(sec_count), 32'd6);

    wr(4'd9, 8'h96);
    inj(4'd9, 4'd5, 4'd5, 1'b0);
    scrub_en = 1'b1;
    wait_scrub_sec("wb_wait2");
    rst = 1'b0;
    #1;
    chk("mid_valid", 32'(rd_valid), 32'd0);
    chk("mid_data", 32'(rd_data), 32'd0);
    chk("mid_sec", 32'(rd_sec), 32'd0);
    chk("mid_ded", 32'(rd_ded), 32'd0);
    chk("mid_seccnt", 32'(sec_count), 32'd0);
    chk("mid_dedcnt", 32'(ded_count), 32'd0);
    chk("mid_busy", 32'(scrub_busy), 32'd0);
    scrub_en = 1'b0;
    step();
    rst = 1'b1;
    step();
    rd("clr9", 4'd9, 8'h00, 1'b0, 1'b0);
    rd("clr3", 4'd3, 8'h00, 1'b0, 1'b0);
    rd("clr10", 4'd10, 8'h00, 1'b0, 1'b0);

    inj(4'd2, 4'd1, 4'd1, 1'b0);
    rd_en = 1'b1;
    rd_addr = 4'd2;
    repeat (65536) step();
    rd_en = 1'b0;
    chk("sat_sec", 32'(rd_sec), 32'd1);
    chk("sat_cnt", 32'(sec_count), 32'hFFFF);
    step();
    chk("sat_hold", 32'(sec_count), 32'hFFFF);
    chk("sat_ded", 32'(ded_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hsiao_ecc_scrub_memory.md
HSIAO_ECC_SCRUB_MEMORY -- requirements
Module: hsiao_ecc_scrub_memory

Interface
REQ-001 Parameter DATA_W, default 8: data word width; legal values 8, 16, 32.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2^ADDR_W words.
REQ-003 Parameter SCRUB_INTERVAL, default 64: idle cycles between scrub accesses; legal range 1..65535.
REQ-004 Derived CHECK_W SHALL be 5/6/7 for DATA_W 8/16/32; CW = DATA_W+CHECK_W; BW = clog2(CW).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  host write strobe.
REQ-008 wr_addr  in  ADDR_W  host write address.
REQ-009 wr_data  in  DATA_W  host write data; encoded before storage.
REQ-010 rd_en  in  1  host read strobe.
REQ-011 rd_addr  in  ADDR_W  host read address.
REQ-012 rd_valid  out  1  read result valid, one-cycle pulse.
REQ-013 rd_data  out  DATA_W  corrected read data.
REQ-014 rd_sec  out  1  single-bit error corrected on this read.
REQ-015 rd_ded  out  1  double-bit error detected on this read.
REQ-016 inj_en  in  1  fault injection strobe; flips stored bits.
REQ-017 inj_two_bit  in  1  1 = flip inj_bit1 and inj_bit2, 0 = flip inj_bit1 only.
REQ-018 inj_addr  in  ADDR_W  word targeted by injection.
REQ-019 inj_bit1, inj_bit2  in  BW  codeword bit indices; values >= CW ignored (no flip).
REQ-020 scrub_en  in  1  enables background scrubbing.
REQ-021 sec_count, ded_count  out  16  saturating error counters (host reads plus scrub).
REQ-022 scrub_busy  out  1  high whenever scrub FSM is not in IDLE.

Function
REQ-023 Encoding SHALL use a Hsiao odd-weight-column SEC-DED code; all-zero data encodes to the all-zero codeword.
REQ-024 Write: wr_en at edge N stores encode(wr_data) at wr_addr; visible to reads issued at edge N+1 onward.
REQ-025 Read: rd_en at edge N -> rd_valid=1 with rd_data/rd_sec/rd_ded valid for the cycle after edge N; latency 1.
REQ-026 Same-address wr_en and rd_en at the same edge SHALL return the old stored word (read-before-write).
REQ-027 Decode: zero syndrome -> data unchanged, flags 0; odd-weight matching syndrome -> bit corrected, rd_sec=1; even-weight nonzero syndrome -> rd_ded=1, rd_data = raw stored data bits; odd-weight unmatched syndrome SHALL be reported as rd_ded.
REQ-028 Host reads SHALL NOT write back corrected data.
REQ-029 Injection: inj_en XORs the selected bit(s) into the stored word at inj_addr; inj_bit1==inj_bit2 with inj_two_bit=1 flips nothing.
REQ-030 Port priority per edge: wr_en > inj_en (same address only; different addresses both proceed) > scrub access; host read never blocked.
REQ-031 Scrub FSM states IDLE, WAIT, READ, CHECK, WRITEBACK.
REQ-032 IDLE -> WAIT when scrub_en=1; WAIT counts SCRUB_INTERVAL cycles, then -> READ; scrub_en=0 in any state returns FSM to IDLE next edge and aborts pending write-back.
REQ-033 READ samples word at scrub_ptr unless wr_en or inj_en active that cycle (stall in READ); -> CHECK.
REQ-034 CHECK: SEC -> WRITEBACK; DED or clean -> WAIT with scrub_ptr+1.
REQ-035 WRITEBACK stores re-encoded corrected word; skipped if wr_en or inj_en targets scrub_ptr that cycle; stalls one cycle on other wr_en; then -> WAIT, scrub_ptr+1.
REQ-036 scrub_ptr SHALL wrap DEPTH-1 -> 0.
REQ-037 Counters increment by 1 per SEC/DED event (host read and scrub CHECK separately; both same cycle -> +2), saturate at 65535.

Reset
REQ-038 rst low SHALL immediately clear: all words to zero codeword, rd_valid/rd_sec/rd_ded/rd_data to 0, counters to 0, scrub_ptr 0, FSM IDLE, interval counter 0.
REQ-039 rst asserted mid-scrub SHALL abandon any write-back; no partial word stored.

Verification
REQ-040 Write 0xA5 addr 3, read addr 3 -> next cycle rd_data=0xA5, rd_sec=0, rd_ded=0.
REQ-041 Inject single flip bit 2 at addr 3, read -> rd_data=0xA5, rd_sec=1, sec_count=1; read again -> rd_sec=1 (no host write-back).
REQ-042 Inject two flips bits 0,7 at addr 5, read -> rd_ded=1, ded_count=1.
REQ-043 SCRUB_INTERVAL=4, single flip at addr 3, scrub_en=1 for full pass -> sec_count incremented, later read of addr 3 -> rd_sec=0, data 0xA5.
REQ-044 Host write to scrub_ptr address during WRITEBACK -> host data retained, write-back skipped.
REQ-045 Force 65536 SEC reads -> sec_count holds 65535; rst low mid-WRITEBACK -> all outputs 0, memory cleared.
